// File: rtl/grid_mem_clr.sv
// grid_mem_clr: playfield row memory with a row-clear / full-wipe engine.
// Port A is the game-logic read/write port. Port B is the read-only display port.
// The engine walks a cursor from a start row up to row 0, one row per cycle.
module grid_mem_clr #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COLS-1:0]       data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  output logic [COLS-1:0]       q_a,
  output logic                  full_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [COLS-1:0]       q_b,
  input  logic                  clr_req,
  input  logic [ADDR_WIDTH-1:0] clr_row,
  input  logic                  wipe_req,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WIPE,
    DONE
  } state_e;

  // One extra bit so that ROWS == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   ROWS_X   = (ADDR_WIDTH+1)'(ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < ROWS_X;
  endfunction

  logic [COLS-1:0] mem [ROWS];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [COLS-1:0]       q_a_q, q_a_d;
  logic [COLS-1:0]       q_b_q, q_b_d;

  logic                  a_acc;
  logic                  eng_we;
  logic [COLS-1:0]       eng_data;
  logic [ADDR_WIDTH-1:0] prev_row;

  // State and cursor register; reset lands in WIPE so the array is cleared on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WIPE;
      cur_q   <= LAST_ROW;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  // Next-state and cursor logic; wipe takes priority over clear in IDLE.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    unique case (state_q)
      IDLE: begin
        if (wipe_req) begin
          state_d = WIPE;
          cur_d   = LAST_ROW;
        end else if (clr_req && in_range(clr_row)) begin
          state_d = SHIFT;
          cur_d   = clr_row;
        end
      end
      SHIFT, WIPE: begin
        if (cur_q == '0) begin
          state_d = DONE;
        end else begin
          cur_d = cur_q - ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Engine outputs: status flags and the row write issued at the cursor.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    eng_we   = 1'b0;
    eng_data = '0;
    prev_row = '0;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        busy   = 1'b1;
        eng_we = 1'b1;
        // Row above is only looked up when one exists, so the cursor never wraps.
        if (cur_q != '0) begin
          prev_row = cur_q - ADDR_WIDTH'(1);
          eng_data = mem[prev_row];
        end
      end
      WIPE: begin
        busy   = 1'b1;
        eng_we = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign a_acc = we_a && !busy && in_range(addr_a);

  // Row storage; port A and the engine never write together because A is blocked while busy.
  always_ff @(posedge clk) begin
    if (a_acc) begin
      mem[addr_a] <= data_a;
    end else if (eng_we) begin
      mem[cur_q] <= eng_data;
    end
  end

  // Port A next read value: write-first, out-of-range rows read as zero.
  always_comb begin
    q_a_d = '0;
    if (a_acc) begin
      q_a_d = data_a;
    end else if (in_range(addr_a)) begin
      q_a_d = mem[addr_a];
    end
  end

  // Port B next read value with bypass of any write to the same row this cycle.
  always_comb begin
    q_b_d = '0;
    if (a_acc && (addr_a == addr_b)) begin
      q_b_d = data_a;
    end else if (eng_we && (cur_q == addr_b)) begin
      q_b_d = eng_data;
    end else if (in_range(addr_b)) begin
      q_b_d = mem[addr_b];
    end
  end

  // Read data registers for both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a    = q_a_q;
  assign q_b    = q_b_q;
  assign full_a = &q_a_q;

endmodule
